// File: rtl/huc_map_pkg.sv
// HuCard mapper shared types: bus structs, mapping modes, register base, mask helper.
// Pure declarations; no logic or latency.
// No flow control; the HuCard bus is a plain strobed interface.
package huc_map_pkg;

  typedef enum logic [1:0] {
    MAP_LINEAR = 2'd0,
    MAP_SPLIT  = 2'd1,
    MAP_SF2    = 2'd2
  } MapMode;

  // Bank register window $001FF0..$001FF3; compare uses bits [20:2]
  localparam logic [20:0] SF2_REG_BASE = 21'h001FF0;

  // Widest ROM address carried in the MemCtrl struct; ROM_AW must not exceed it
  localparam int MAX_AW = 24;

  typedef struct packed {
    logic [20:0] addr;
    logic [7:0]  data;
    logic        ce;
    logic        oe;
    logic        we;
  } CpuBus;

  typedef struct packed {
    CpuBus       cpu;
    logic [7:0]  rom_q;
    logic [7:0]  ram_q;
  } HucIn;

  typedef struct packed {
    logic              ce;
    logic              ce2;
    logic              oe;
    logic              we;
    logic [MAX_AW-1:0] addr;
    logic [7:0]        dati;
  } MemCtrl;

  typedef struct packed {
    MemCtrl      rom;
    MemCtrl      ram;
    logic        cart_ce;
    logic [7:0]  cart_dato;
  } HucOut;

  // Byte mask for a power-of-two segment given in KB
  function automatic logic [31:0] seg_mask(input int kb);
    return (32'(kb) * 32'd1024) - 32'd1;
  endfunction

endpackage

// File: rtl/huc_bank_reg.sv
// SF2 bank register: latches sel mod BANKS on the rising edge of the qualified write strobe.
// New bank visible one clock after the edge.
// No backpressure; held or back-to-back strobes latch only once.
module huc_bank_reg
  import huc_map_pkg::*;
#(
  parameter int BANKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic [1:0] sel,
  output logic [1:0] bank_o
);

  logic [1:0] bank_q, bank_d;
  logic       wr_q;
  // arm_q stays low for the first cycle out of reset so a strobe that
  // was already active across reset release is treated as held, not new
  logic       arm_q;
  logic       rise;

  assign rise = hit & ~wr_q & arm_q;

  // Next bank: reduced selector on a fresh write edge, otherwise hold
  always_comb begin
    bank_d = bank_q;
    if (rise) bank_d = 2'(({1'b0, sel}) % 3'(BANKS));
  end

  // Bank, edge-detect and arm state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= 2'd0;
      wr_q   <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      wr_q   <= hit;
      arm_q  <= 1'b1;
    end
  end

  assign bank_o = bank_q;

endmodule

// File: rtl/huc_map.sv
// HuCard mapper: CPU physical address -> cart ROM address (linear, split, SF2 banked).
// Zero latency on address/strobes; SF2 bank change visible one clock after the write edge.
// No backpressure; CPU strobes pass straight through to the ROM controller.
module huc_map
  import huc_map_pkg::*;
#(
  parameter MapMode MAP_MODE  = MAP_SPLIT,
  parameter int     SEG_A_KB  = 256,
  parameter int     SEG_B_KB  = 128,
  parameter int     SF2_BANKS = 4,
  parameter int     ROM_AW    = 22
) (
  input  logic  clk,
  input  logic  rst_n,
  input  HucIn  huc_i,
  output HucOut huc_o
);

  if (ROM_AW > MAX_AW) begin : g_err_aw
    $error("huc_map: ROM_AW exceeds MAX_AW");
  end
  if ((SEG_A_KB + SEG_B_KB) * 1024 > (1 << ROM_AW)) begin : g_err_seg
    $error("huc_map: SEG_A + SEG_B exceeds ROM address space");
  end
  if ((SF2_BANKS + 1) * 512 * 1024 > (1 << ROM_AW)) begin : g_err_sf2
    $error("huc_map: SF2 banks exceed ROM address space");
  end
  if (SF2_BANKS < 1 || SF2_BANKS > 4) begin : g_err_banks
    $error("huc_map: SF2_BANKS must be 1..4");
  end

  localparam logic [31:0] MASK_A = seg_mask(SEG_A_KB);
  localparam logic [31:0] MASK_B = seg_mask(SEG_B_KB);
  localparam logic [31:0] BASE_B = 32'(SEG_A_KB) * 32'd1024;
  localparam logic [31:0] AW_MASK = (32'd1 << ROM_AW) - 32'd1;

  logic [31:0] a32;
  logic [31:0] rom_addr32;

  assign a32 = {11'b0, huc_i.cpu.addr};

  if (MAP_MODE == MAP_LINEAR) begin : g_linear
    logic unused_clkrst;
    assign unused_clkrst = clk ^ rst_n;
    // Linear: mirror ROM across the window
    always_comb rom_addr32 = a32 & MASK_A;
  end else if (MAP_MODE == MAP_SPLIT) begin : g_split
    logic unused_clkrst;
    assign unused_clkrst = clk ^ rst_n;
    // Split: lower half -> segment A, upper half -> segment B placed after A
    always_comb begin
      rom_addr32 = a32 & MASK_A;
      if (a32[19]) rom_addr32 = BASE_B + (a32 & MASK_B);
    end
  end else begin : g_sf2
    logic       hit;
    logic [1:0] bank;

    assign hit = huc_i.cpu.ce & huc_i.cpu.we &
                 (huc_i.cpu.addr[20:2] == SF2_REG_BASE[20:2]);

    huc_bank_reg #(
      .BANKS (SF2_BANKS)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .hit    (hit),
      .sel    (huc_i.cpu.addr[1:0]),
      .bank_o (bank)
    );

    // SF2: lower 512K fixed, upper 512K window selects bank+1
    always_comb begin
      rom_addr32 = {13'b0, a32[18:0]};
      if (a32[19]) rom_addr32 = (32'({1'b0, bank} + 3'd1) << 19) | {13'b0, a32[18:0]};
    end
  end

  // Strobe pass-through and read-data steering
  always_comb begin
    huc_o          = '0;
    huc_o.rom.ce   = ~huc_i.cpu.addr[20];
    huc_o.rom.ce2  = huc_i.cpu.ce;
    huc_o.rom.oe   = huc_i.cpu.oe;
    huc_o.rom.we   = 1'b0;
    huc_o.rom.addr = MAX_AW'(rom_addr32 & AW_MASK);
    huc_o.rom.dati = huc_i.cpu.data;
    huc_o.ram.ce   = 1'b0;
    huc_o.cart_ce  = huc_o.rom.ce | huc_o.ram.ce;
    huc_o.cart_dato = huc_o.rom.ce ? huc_i.rom_q : huc_i.ram_q;
  end

endmodule
